// File: rtl/do_xung.sv
`default_nettype none
// ============================================================================
//  Module      : do_xung
//  Description : Ramp-generator lock detector. Tracks a stepped sawtooth on D,
//                measures peak, step width and period, and recovers the two
//                generator mode bits from the (peak, step) pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module do_xung #(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  D,
    output logic [15:0]   peak,
    output logic [7:0]    step_clks,
    output logic [23:0]   period,
    output logic          Smode_det,
    output logic          Fmode_det,
    output logic          locked,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t         state, state_nxt;

    logic [W-1:0]   d_q, d_prev;
    logic [7:0]     gap_cnt;
    logic [23:0]    per_cnt;
    logic [7:0]     first_gap;
    logic           have_gap, gap_bad;

    logic [W:0]     prev_plus1;
    logic           change, is_inc, is_wrap, is_glitch, timeout;
    logic [31:0]    prev_ext;
    logic           gaps_ok, code_ok, code_s, code_f;

    logic [15:0]    peak_nxt;
    logic [7:0]     step_nxt;
    logic [23:0]    period_nxt;
    logic           s_nxt, f_nxt, locked_nxt, err_nxt;

    // Increment test is done one bit wider so an all-ones sample never aliases to 0.
    assign prev_plus1 = {1'b0, d_prev} + {{W{1'b0}}, 1'b1};
    assign change     = (d_q != d_prev);
    assign is_inc     = change && ({1'b0, d_q} == prev_plus1);
    assign is_wrap    = (d_q == '0) && (d_prev != '0);
    assign is_glitch  = change && !is_inc && !is_wrap;
    // gap_cnt holds the length of the gap in progress including this clock;
    // reaching TIMEOUT means the gap is about to exceed it.
    assign timeout    = (32'(gap_cnt) >= 32'(TIMEOUT));
    assign prev_ext   = 32'(d_prev);

    // The cycle is consistent only if every gap, including the one ending in the wrap,
    // matches the first gap of the cycle.
    assign gaps_ok = have_gap && !gap_bad && (gap_cnt == first_gap);

    // Decode the (peak, step) pair seen at this wrap into the generator mode bits.
    always_comb begin
        code_ok = 1'b0;
        code_s  = 1'b0;
        code_f  = 1'b0;
        if (gaps_ok) begin
            if (prev_ext == 32'd1000 && gap_cnt == 8'd10) begin
                code_ok = 1'b1;
            end else if (prev_ext == 32'd1000 && gap_cnt == 8'd20) begin
                code_ok = 1'b1;
                code_f  = 1'b1;
            end else if (prev_ext == 32'd500 && gap_cnt == 8'd20) begin
                code_ok = 1'b1;
                code_s  = 1'b1;
            end else if (prev_ext == 32'd500 && gap_cnt == 8'd40) begin
                code_ok = 1'b1;
                code_s  = 1'b1;
                code_f  = 1'b1;
            end
        end
    end

    // Sample pipeline, gap/period counters and per-cycle gap consistency tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q       <= '0;
            d_prev    <= '0;
            gap_cnt   <= 8'd0;
            per_cnt   <= 24'd0;
            first_gap <= 8'd0;
            have_gap  <= 1'b0;
            gap_bad   <= 1'b0;
        end else begin
            d_q    <= D;
            d_prev <= d_q;

            if (change) begin
                gap_cnt <= 8'd1;
            end else if (gap_cnt != 8'hFF) begin
                gap_cnt <= gap_cnt + 8'd1;
            end

            if (is_wrap) begin
                per_cnt <= 24'd1;
            end else if (per_cnt != 24'hFF_FFFF) begin
                per_cnt <= per_cnt + 24'd1;
            end

            if (is_wrap) begin
                have_gap <= 1'b0;
                gap_bad  <= 1'b0;
            end else if (is_inc) begin
                if (!have_gap) begin
                    have_gap  <= 1'b1;
                    first_gap <= gap_cnt;
                end else if (gap_cnt != first_gap) begin
                    gap_bad <= 1'b1;
                end
            end
        end
    end

    // State and measurement/status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            peak      <= 16'd0;
            step_clks <= 8'd0;
            period    <= 24'd0;
            Smode_det <= 1'b0;
            Fmode_det <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            peak      <= peak_nxt;
            step_clks <= step_nxt;
            period    <= period_nxt;
            Smode_det <= s_nxt;
            Fmode_det <= f_nxt;
            locked    <= locked_nxt;
            err       <= err_nxt;
        end
    end

    // Next state and outputs; timeout outranks glitch, which outranks a wrap.
    always_comb begin
        state_nxt  = state;
        peak_nxt   = peak;
        step_nxt   = step_clks;
        period_nxt = period;
        s_nxt      = Smode_det;
        f_nxt      = Fmode_det;
        locked_nxt = locked;
        err_nxt    = err;

        if (state != IDLE && timeout) begin
            state_nxt  = IDLE;
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
        end else if (state != IDLE && is_glitch) begin
            state_nxt  = SYNC;
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (change) state_nxt = SYNC;
                end
                SYNC: begin
                    if (is_wrap) state_nxt = TRACK;
                end
                TRACK, LOCK: begin
                    if (is_wrap) begin
                        peak_nxt   = 16'(d_prev);
                        step_nxt   = gap_cnt;
                        period_nxt = per_cnt;
                        if (code_ok) begin
                            state_nxt  = LOCK;
                            s_nxt      = code_s;
                            f_nxt      = code_f;
                            locked_nxt = 1'b1;
                            if (state == TRACK) err_nxt = 1'b0;
                        end else begin
                            state_nxt  = SYNC;
                            locked_nxt = 1'b0;
                            err_nxt    = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
